// File: rtl/video_timing_det.sv
// Video timing detector: measures active/total geometry of a vs/hs/de stream and locks on a stable format.
// Optional frame counter output enabled by defining VTD_FRAME_CNT_EN.
module video_timing_det #(
   parameter int X_BITS      = 13,
   parameter int Y_BITS      = 13,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              pix_clk,
   input  logic              rst,
   input  logic              vs_in,
   input  logic              hs_in,
   input  logic              de_in,
   output logic              vs_out,
   output logic              hs_out,
   output logic              de_out,
   output logic [X_BITS-1:0] act_x,
   output logic [Y_BITS-1:0] act_y,
   output logic [11:0]       h_act,
   output logic [11:0]       v_act,
   output logic [11:0]       h_total,
   output logic [11:0]       v_total,
   output logic              locked,
`ifdef VTD_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   output logic              fmt_change
);

   typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [11:0]       CMAX   = 12'hFFF;
   localparam logic [X_BITS-1:0] X_ONE  = {{(X_BITS-1){1'b0}}, 1'b1};
   localparam logic [Y_BITS-1:0] Y_ONE  = {{(Y_BITS-1){1'b0}}, 1'b1};
   localparam logic [4:0]        LOCK_N = 5'(LOCK_FRAMES);

   function automatic logic [11:0] sat_inc12(input logic [11:0] v);
      return (v == CMAX) ? v : v + 12'd1;
   endfunction

   state_t            state_q, state_d;
   logic              vs_dly_q, hs_dly_q, de_dly_q;
   logic [X_BITS-1:0] act_x_q, act_x_d;
   logic [Y_BITS-1:0] act_y_q, act_y_d;
   logic [11:0]       hcyc_q, hcyc_d, last_hcyc_q, last_hcyc_d;
   logic [11:0]       pix_q, pix_d, lines_q, lines_d, hlines_q, hlines_d;
   logic [11:0]       ref_pix_q, ref_pix_d;
   logic              ref_vld_q, ref_vld_d, bad_q, bad_d;
   logic [3:0]        match_q, match_d;
   logic [47:0]       prev_q, prev_d;
   logic              prev_vld_q, prev_vld_d;
   logic [11:0]       h_act_q, h_act_d, v_act_q, v_act_d;
   logic [11:0]       h_total_q, h_total_d, v_total_q, v_total_d;
   logic              locked_q, locked_d, fmt_change_q, fmt_change_d;

   logic              vs_rise_s, hs_rise_s, de_rise_s, de_fall_s;
   logic [11:0]       last_hcyc_nx_s, hlines_nx_s, lines_nx_s, ref_pix_nx_s;
   logic              ref_vld_nx_s, bad_nx_s;
   logic [47:0]       cand_s;
   logic              cand_ok_s, loss_s;
   logic [3:0]        match_nx_s;

   assign vs_rise_s = vs_in & ~vs_dly_q;
   assign hs_rise_s = hs_in & ~hs_dly_q;
   assign de_rise_s = de_in & ~de_dly_q;
   assign de_fall_s = ~de_in & de_dly_q;

   // A hs edge coincident with vs_rise still belongs to the closing frame.
   assign last_hcyc_nx_s = hs_rise_s ? hcyc_q : last_hcyc_q;
   assign hlines_nx_s    = hs_rise_s ? sat_inc12(hlines_q) : hlines_q;
   assign lines_nx_s     = de_rise_s ? sat_inc12(lines_q) : lines_q;

   always_comb begin
      ref_pix_nx_s = ref_pix_q;
      ref_vld_nx_s = ref_vld_q;
      bad_nx_s     = bad_q;
      if (de_fall_s) begin
         if (!ref_vld_q) begin
            ref_pix_nx_s = pix_q;
            ref_vld_nx_s = 1'b1;
         end else if (pix_q != ref_pix_q) begin
            bad_nx_s = 1'b1;
         end else begin
            bad_nx_s = bad_q;
         end
      end else begin
         ref_vld_nx_s = ref_vld_q;
      end
   end

   assign cand_s    = {ref_pix_nx_s, lines_nx_s, last_hcyc_nx_s, hlines_nx_s};
   assign cand_ok_s = ref_vld_nx_s & ~bad_nx_s & (lines_nx_s != 12'd0) &
                      (ref_pix_nx_s != CMAX) & (lines_nx_s != CMAX) &
                      (last_hcyc_nx_s != CMAX) & (hlines_nx_s != CMAX) & (hcyc_q != CMAX);

   always_comb begin
      act_x_d = act_x_q;
      if (de_fall_s) begin
         act_x_d = '0;
      end else if (de_dly_q && (act_x_q != {X_BITS{1'b1}})) begin
         act_x_d = act_x_q + X_ONE;
      end else begin
         act_x_d = act_x_q;
      end

      act_y_d = act_y_q;
      if (vs_rise_s) begin
         act_y_d = '0;
      end else if (de_fall_s && (act_y_q != {Y_BITS{1'b1}})) begin
         act_y_d = act_y_q + Y_ONE;
      end else begin
         act_y_d = act_y_q;
      end

      hcyc_d      = hs_rise_s ? 12'd1 : sat_inc12(hcyc_q);
      last_hcyc_d = last_hcyc_nx_s;
      pix_d       = de_rise_s ? 12'd1 : (de_in ? sat_inc12(pix_q) : pix_q);
      ref_pix_d   = ref_pix_nx_s;

      if (vs_rise_s) begin
         lines_d   = 12'd0;
         hlines_d  = 12'd0;
         ref_vld_d = 1'b0;
         bad_d     = 1'b0;
      end else begin
         lines_d   = lines_nx_s;
         hlines_d  = hlines_nx_s;
         ref_vld_d = ref_vld_nx_s;
         bad_d     = bad_nx_s;
      end
   end

   always_comb begin
      state_d      = state_q;
      match_d      = match_q;
      prev_d       = prev_q;
      prev_vld_d   = prev_vld_q;
      h_act_d      = h_act_q;
      v_act_d      = v_act_q;
      h_total_d    = h_total_q;
      v_total_d    = v_total_q;
      locked_d     = locked_q;
      fmt_change_d = 1'b0;
      loss_s       = 1'b0;
      match_nx_s   = 4'd0;
      if (cand_ok_s && prev_vld_q && (cand_s == prev_q)) begin
         match_nx_s = (match_q == 4'hF) ? match_q : match_q + 4'd1;
      end else begin
         match_nx_s = 4'd0;
      end

      case (state_q)
         SEARCH: begin
            if (vs_rise_s) begin
               state_d    = MEASURE;
               match_d    = 4'd0;
               prev_vld_d = 1'b0;
            end else begin
               state_d = SEARCH;
            end
         end
         MEASURE: begin
            if (vs_rise_s) begin
               match_d = match_nx_s;
               if (match_nx_s == 4'd0) begin
                  prev_d     = cand_s;
                  prev_vld_d = cand_ok_s;
               end else begin
                  prev_d = prev_q;
               end
               if (cand_ok_s && (({1'b0, match_nx_s} + 5'd1) >= LOCK_N)) begin
                  h_act_d   = ref_pix_nx_s;
                  v_act_d   = lines_nx_s;
                  h_total_d = last_hcyc_nx_s;
                  v_total_d = hlines_nx_s;
                  locked_d  = 1'b1;
                  match_d   = 4'd0;
                  state_d   = LOCKED;
               end else begin
                  state_d = MEASURE;
               end
            end else begin
               state_d = MEASURE;
            end
         end
         LOCKED: begin
            // Loss of hs entirely restarts from SEARCH rather than MEASURE.
            if (hcyc_q == CMAX) begin
               loss_s       = 1'b1;
               locked_d     = 1'b0;
               fmt_change_d = 1'b1;
               match_d      = 4'd0;
               prev_vld_d   = 1'b0;
               state_d      = SEARCH;
            end else if (vs_rise_s && (!cand_ok_s ||
                         (cand_s != {h_act_q, v_act_q, h_total_q, v_total_q}))) begin
               loss_s       = 1'b1;
               locked_d     = 1'b0;
               fmt_change_d = 1'b1;
               match_d      = 4'd0;
               prev_vld_d   = 1'b0;
               state_d      = MEASURE;
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d  = SEARCH;
            locked_d = 1'b0;
         end
      endcase
   end

`ifdef VTD_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      if (loss_s) begin
         frame_cnt_d = 16'd0;
      end else if ((state_q == LOCKED) && vs_rise_s) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         state_q      <= SEARCH;
         vs_dly_q     <= 1'b0;
         hs_dly_q     <= 1'b0;
         de_dly_q     <= 1'b0;
         act_x_q      <= '0;
         act_y_q      <= '0;
         hcyc_q       <= 12'd0;
         last_hcyc_q  <= 12'd0;
         pix_q        <= 12'd0;
         lines_q      <= 12'd0;
         hlines_q     <= 12'd0;
         ref_pix_q    <= 12'd0;
         ref_vld_q    <= 1'b0;
         bad_q        <= 1'b0;
         match_q      <= 4'd0;
         prev_q       <= 48'd0;
         prev_vld_q   <= 1'b0;
         h_act_q      <= 12'd0;
         v_act_q      <= 12'd0;
         h_total_q    <= 12'd0;
         v_total_q    <= 12'd0;
         locked_q     <= 1'b0;
         fmt_change_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_dly_q     <= vs_in;
         hs_dly_q     <= hs_in;
         de_dly_q     <= de_in;
         act_x_q      <= act_x_d;
         act_y_q      <= act_y_d;
         hcyc_q       <= hcyc_d;
         last_hcyc_q  <= last_hcyc_d;
         pix_q        <= pix_d;
         lines_q      <= lines_d;
         hlines_q     <= hlines_d;
         ref_pix_q    <= ref_pix_d;
         ref_vld_q    <= ref_vld_d;
         bad_q        <= bad_d;
         match_q      <= match_d;
         prev_q       <= prev_d;
         prev_vld_q   <= prev_vld_d;
         h_act_q      <= h_act_d;
         v_act_q      <= v_act_d;
         h_total_q    <= h_total_d;
         v_total_q    <= v_total_d;
         locked_q     <= locked_d;
         fmt_change_q <= fmt_change_d;
      end
   end

   assign vs_out     = vs_dly_q;
   assign hs_out     = hs_dly_q;
   assign de_out     = de_dly_q;
   assign act_x      = act_x_q;
   assign act_y      = act_y_q;
   assign h_act      = h_act_q;
   assign v_act      = v_act_q;
   assign h_total    = h_total_q;
   assign v_total    = v_total_q;
   assign locked     = locked_q;
   assign fmt_change = fmt_change_q;

endmodule

// File: doc/video_timing_det.md
Name: video_timing_det

Overview:
- Receive-side counterpart of the pattern generator. It consumes a raw vs/hs/de timing stream and measures the active and total geometry of each frame.
- Produces per-pixel act_x/act_y coordinates and publishes measured h_act/v_act once the format is stable for LOCK_FRAMES consecutive frames.
- Sits between the incoming video timing and any pattern/processing stage that needs H_ACT/V_ACT and pixel coordinates.

Parameters:
X_BITS, 13, width of act_x
Y_BITS, 13, width of act_y
LOCK_FRAMES, 2, consecutive identical frames required to lock (legal range 1..15)

Ports:
pix_clk  input  1  pixel clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
vs_in  input  1  vertical sync, active high
hs_in  input  1  horizontal sync, active high
de_in  input  1  data enable, active high
vs_out  output  1  vs_in delayed 1 cycle
hs_out  output  1  hs_in delayed 1 cycle
de_out  output  1  de_in delayed 1 cycle
act_x  output  X_BITS  pixel index within active line, aligned with de_out
act_y  output  Y_BITS  active line index within frame, aligned with de_out
h_act  output  12  locked active pixels per line
v_act  output  12  locked active lines per frame
h_total  output  12  locked pix_clk cycles per line (hs rise to hs rise)
v_total  output  12  locked lines per frame (hs rises between vs rises)
locked  output  1  published geometry valid
fmt_change  output  1  one-cycle pulse on loss of lock

Behaviour:
- Reset: all outputs 0, FSM to SEARCH, all counters and the match count cleared. Reset mid-frame discards partial measurements.
- Inputs are registered once into vs_d, hs_d, de_d, which drive vs_out, hs_out and de_out. Latency is 1 cycle.
- Edge detects use the registered signal and the current input. vs_rise = vs_in & ~vs_d. Likewise for hs_rise, de_rise and de_fall.
- Coordinates:
  - act_x resets to 0 on the cycle after de_fall, and increments on each cycle where de_d=1.
  - act_x therefore equals 0 on the first de_out cycle of a line.
  - act_y resets to 0 on vs_rise and increments on each de_fall.
  - act_x and act_y saturate at all-ones.
- Measurement counters (12-bit, saturating at 4095):
  - hcyc counts cycles between hs_rise events.
  - pix counts de cycles per line. The first line's pix is stored as ref_pix at that line's de_fall.
  - A later line whose pix != ref_pix sets the bad flag.
  - lines counts de_rise events per frame; hlines counts hs_rise events per frame.
- Frame boundary is vs_rise. Candidate = {ref_pix, lines, last hcyc, hlines}.
  - Candidate is invalid if bad=1, any counter saturated, or lines=0.
  - Per-frame counters and bad clear on the same cycle.
- FSM states:
  - SEARCH: wait for the first vs_rise (partial frame discarded), then go to MEASURE with match=0.
  - MEASURE: on each vs_rise:
    - If the candidate is valid and equals the previous candidate, match++. Otherwise match=0 and the previous candidate is overwritten.
    - When match+1 reaches LOCK_FRAMES, load h_act/v_act/h_total/v_total, set locked=1 and go to LOCKED.
    - LOCK_FRAMES=1 locks on the first valid candidate.
  - LOCKED: on each vs_rise:
    - If the candidate differs from the published values or is invalid: locked=0, fmt_change=1 for one cycle, published values held, go to MEASURE with match=0.
    - If hcyc saturates (no hs for 4095 cycles), apply the same loss handling but go to SEARCH.
- Published h_act/v_act/h_total/v_total change only on entry to LOCKED.
- Simultaneous vs_rise and hs_rise: the hs edge is counted in the closing frame's hlines before clearing.

Optional Feature:
- Macro VTD_FRAME_CNT_EN.
- When defined: adds output port frame_cnt (16 bits).
  - Increments on each vs_rise while in LOCKED, and wraps 65535->0.
  - Clears to 0 on reset and on loss of lock.
- When undefined: frame_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with random inputs toggling -> all outputs 0, locked=0, fmt_change=0 through the reset cycle and the first cycle after.
- Stable timing: h_act=16, h_total=24, v_act=8, v_total=12, LOCK_FRAMES=2.
  - locked rises on the 3rd vs_rise (first partial frame discarded), with h_act=16, v_act=8, h_total=24, v_total=12.
  - act_x runs 0..15 and act_y 0..7, both aligned with de_out.
- After lock, switch to h_act=20 -> fmt_change pulses exactly one cycle at the next vs_rise, locked=0; relock with h_act=20 two frames later.
- Within one frame, one line with 15 de cycles among 16-cycle lines -> frame rejected, match resets, lock delayed by one extra frame.
- Hold hs_in low for 5000 cycles while locked -> fmt_change pulse at hcyc saturation, FSM in SEARCH; relock after normal timing resumes.
- With VTD_FRAME_CNT_EN: 5 locked frames -> frame_cnt=5; force loss of lock -> frame_cnt=0.
